// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction memory. A program arrives as a byte stream
//   (valid/ready): a 16-bit big-endian word count, that many 32-bit words sent
//   MSB first, then one checksum byte (XOR of all data bytes). Each assembled
//   word is written sequentially into the instruction memory write port. The
//   CPU is held in reset (cpu_rst) until a complete image with a matching
//   checksum has been loaded.
//
// Ports
//   clk          system clock, all logic on rising edge
//   rst          synchronous, active-high reset
//   start        1-cycle pulse, begins a load (honoured in IDLE/DONE/ERR only)
//   rx_data      incoming stream byte
//   rx_valid     rx_data valid
//   rx_ready     loader accepts a byte this cycle
//   imem_we      instruction memory write strobe (one cycle per word)
//   imem_addr    byte address of the word being written
//   imem_wdata   word being written
//   cpu_rst      processor reset, high until a successful load
//   busy         high while a load is in progress
//   done         image loaded and checksum good
//   error        load failed (oversized count or bad checksum)
//   words_loaded words written in the current/last load
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [31:0]           imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  // Largest image that fits the memory; compared at 17 bits so a 16-bit
  // count of 65535 can never alias.
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  state_t              state_reg;
  state_t              state_next;
  logic [15:0]         cnt_reg;
  logic [1:0]          byte_idx_reg;
  logic [31:0]         word_reg;
  logic [7:0]          acc_reg;
  logic [ADDR_WIDTH:0] words_loaded_reg;
  logic                rx_ready_reg;
  logic                imem_we_reg;
  logic [31:0]         imem_addr_reg;
  logic [31:0]         imem_wdata_reg;
  logic                cpu_rst_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                error_reg;

  logic                accept;
  logic [31:0]         word_shift;
  logic [16:0]         hdr_cnt;
  logic [16:0]         wl_plus_one;

  // rx_ready_reg is decoded from the registered state, so a transfer is
  // only ever seen in a receiving state.
  assign accept      = rx_valid && rx_ready_reg;
  assign word_shift  = {word_reg[23:0], rx_data};
  assign hdr_cnt     = {1'b0, cnt_reg[15:8], rx_data};
  assign wl_plus_one = 17'(words_loaded_reg) + 17'd1;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_next = S_HDR0;
      end
      S_HDR0: begin
        if (accept) state_next = S_HDR1;
      end
      S_HDR1: begin
        if (accept) begin
          if (hdr_cnt > MAX_WORDS)   state_next = S_ERR;
          else if (hdr_cnt == 17'd0) state_next = S_CHK;
          else                       state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && byte_idx_reg == 2'd3) state_next = S_WRITE;
      end
      S_WRITE: begin
        if (wl_plus_one == {1'b0, cnt_reg}) state_next = S_CHK;
        else                                state_next = S_DATA;
      end
      S_CHK: begin
        if (accept) state_next = (rx_data == acc_reg) ? S_DONE : S_ERR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      cnt_reg          <= 16'd0;
      byte_idx_reg     <= 2'd0;
      word_reg         <= 32'd0;
      acc_reg          <= 8'd0;
      words_loaded_reg <= '0;
      rx_ready_reg     <= 1'b0;
      imem_we_reg      <= 1'b0;
      imem_addr_reg    <= BASE_ADDR;
      imem_wdata_reg   <= 32'd0;
      cpu_rst_reg      <= 1'b1;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      error_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;

      // Outputs are decoded from the next state so they change on the same
      // edge as the state itself and come straight out of flops.
      rx_ready_reg <= (state_next == S_HDR0) || (state_next == S_HDR1) ||
                      (state_next == S_DATA) || (state_next == S_CHK);
      busy_reg     <= (state_next == S_HDR0) || (state_next == S_HDR1) ||
                      (state_next == S_DATA) || (state_next == S_WRITE) ||
                      (state_next == S_CHK);
      imem_we_reg  <= (state_next == S_WRITE);
      done_reg     <= (state_next == S_DONE);
      error_reg    <= (state_next == S_ERR);
      cpu_rst_reg  <= (state_next != S_DONE);

      case (state_reg)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            words_loaded_reg <= '0;
            byte_idx_reg     <= 2'd0;
            acc_reg          <= 8'd0;
          end
        end
        S_HDR0: begin
          if (accept) cnt_reg[15:8] <= rx_data;
        end
        S_HDR1: begin
          if (accept) cnt_reg[7:0] <= rx_data;
        end
        S_DATA: begin
          if (accept) begin
            word_reg     <= word_shift;
            acc_reg      <= acc_reg ^ rx_data;
            byte_idx_reg <= byte_idx_reg + 2'd1;
            // Latch address and data on the 4th byte so they are stable for
            // the whole WRITE cycle.
            if (byte_idx_reg == 2'd3) begin
              imem_addr_reg  <= BASE_ADDR + (32'(words_loaded_reg) << 2);
              imem_wdata_reg <= word_shift;
            end
          end
        end
        S_WRITE: begin
          words_loaded_reg <= words_loaded_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rx_ready     = rx_ready_reg;
  assign imem_we      = imem_we_reg;
  assign imem_addr    = imem_addr_reg;
  assign imem_wdata   = imem_wdata_reg;
  assign cpu_rst      = cpu_rst_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign error        = error_reg;
  assign words_loaded = words_loaded_reg;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader: a table of directed loads, a few
//   hand-written sequences (mid-load reset, restart from DONE), and random
//   loads compared against a stream-parsing reference model.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam int          AW   = 8;
  localparam logic [31:0] BASE = 32'h0;
  localparam int          MAXW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor, sampled on the falling edge.
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic        prev_we = 1'b0;
  int          we_double = 0;
  int          we_outside = 0;
  always @(negedge clk) begin
    if (imem_we) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
      if (prev_we) we_double++;
      if (!busy) we_outside++;
    end
    prev_we = imem_we;
  end

  // Stream under test and reference-model expectations.
  logic [7:0]  stream_q[$];
  logic [31:0] src_words[$];
  logic [31:0] exp_wa[$];
  logic [31:0] exp_wd[$];
  bit          exp_done, exp_err;
  int          exp_wl, exp_cnt;

  task automatic build_stream(input int cnt, input logic [7:0] ck_xor);
    logic [7:0] x;
    stream_q.delete();
    stream_q.push_back(8'(cnt >> 8));
    stream_q.push_back(8'(cnt));
    if (cnt <= MAXW) begin
      x = 8'd0;
      for (int i = 0; i < cnt; i++) begin
        for (int k = 3; k >= 0; k--) begin
          stream_q.push_back(src_words[i][8*k +: 8]);
          x ^= src_words[i][8*k +: 8];
        end
      end
      stream_q.push_back(x ^ ck_xor);
    end
  endtask

  // Reference model: parses the byte stream directly.
  task automatic model();
    logic [7:0]  x;
    logic [31:0] w;
    exp_wa.delete();
    exp_wd.delete();
    exp_cnt = int'({stream_q[0], stream_q[1]});
    if (exp_cnt > MAXW) begin
      exp_err = 1; exp_done = 0; exp_wl = 0;
    end else begin
      x = 8'd0;
      for (int i = 0; i < exp_cnt; i++) begin
        w = {stream_q[2+4*i], stream_q[3+4*i], stream_q[4+4*i], stream_q[5+4*i]};
        exp_wa.push_back(BASE + 32'(4*i));
        exp_wd.push_back(w);
        x ^= stream_q[2+4*i] ^ stream_q[3+4*i] ^ stream_q[4+4*i] ^ stream_q[5+4*i];
      end
      exp_done = (stream_q[2+4*exp_cnt] == x);
      exp_err  = !exp_done;
      exp_wl   = exp_cnt;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int bound;
    if (gaps) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    bound = 0;
    while (!rx_ready && bound < 100) begin
      @(negedge clk);
      bound++;
    end
    if (bound >= 100) check("rx_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Start a load, push stream_q, check against the model.
  task automatic run_load(input string tag, input bit gaps, input int mid_start);
    wa_q.delete();
    wd_q.delete();
    model();
    pulse_start();
    check({tag, "_cpu_rst_on_start"}, 32'(cpu_rst), 32'd1);
    check({tag, "_busy_on_start"}, 32'(busy), 32'd1);
    for (int i = 0; i < stream_q.size(); i++) begin
      if (i == mid_start) pulse_start();
      send_byte(stream_q[i], gaps);
      if (i >= 2 && (i - 2) < 4 * exp_cnt && ((i - 2) % 4) == 3)
        check({tag, "_we_latency"}, 32'(imem_we), 32'd1);
    end
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!exp_done));
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'(exp_wl));
    check({tag, "_nwrites"}, 32'(wa_q.size()), 32'(exp_wa.size()));
    for (int i = 0; i < exp_wa.size() && i < wa_q.size(); i++) begin
      check({tag, "_waddr"}, wa_q[i], exp_wa[i]);
      check({tag, "_wdata"}, wd_q[i], exp_wd[i]);
    end
    $display("load %s cnt=%0d writes=%0d done=%0b error=%0b words_loaded=%0d",
             tag, exp_cnt, wa_q.size(), done, error, words_loaded);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    check({tag, "_imem_addr"}, imem_addr, BASE);
    check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  typedef struct {
    int          cnt;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  ck_xor;
    bit          gaps;
    int          mid;
    bit          e_done;
    bit          e_err;
    int          e_wl;
    int          e_nwr;
    logic [31:0] e_w0;
  } vec_t;

  vec_t vt[6];

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{2,   32'h20080005, 32'h0, 8'h00, 1'b0, -1, 1'b1, 1'b0, 2, 2, 32'h20080005};
    vt[1] = '{0,   32'h0,        32'h0, 8'h00, 1'b0, -1, 1'b1, 1'b0, 0, 0, 32'h0};
    vt[2] = '{257, 32'h0,        32'h0, 8'h00, 1'b0, -1, 1'b0, 1'b1, 0, 0, 32'h0};
    vt[3] = '{2,   32'h20080005, 32'h0, 8'h01, 1'b0, -1, 1'b0, 1'b1, 2, 2, 32'h20080005};
    vt[4] = '{2,   32'h20080005, 32'h0, 8'h00, 1'b1,  5, 1'b1, 1'b0, 2, 2, 32'h20080005};
    vt[5] = '{1,   32'hDEADBEEF, 32'h0, 8'h00, 1'b1, -1, 1'b1, 1'b0, 1, 1, 32'hDEADBEEF};

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed table.
    for (int v = 0; v < 6; v++) begin
      src_words.delete();
      src_words.push_back(vt[v].w0);
      src_words.push_back(vt[v].w1);
      build_stream(vt[v].cnt, vt[v].ck_xor);
      run_load($sformatf("vec%0d", v), vt[v].gaps, vt[v].mid);
      check("vec_done", 32'(done), 32'(vt[v].e_done));
      check("vec_error", 32'(error), 32'(vt[v].e_err));
      check("vec_words_loaded", 32'(words_loaded), 32'(vt[v].e_wl));
      check("vec_nwrites", 32'(wa_q.size()), 32'(vt[v].e_nwr));
      if (vt[v].e_nwr > 0 && wd_q.size() > 0)
        check("vec_first_word", wd_q[0], vt[v].e_w0);
    end

    // Reset after 6 data bytes of a 3-word load.
    wa_q.delete();
    wd_q.delete();
    src_words.delete();
    for (int i = 0; i < 3; i++) src_words.push_back($urandom);
    build_stream(3, 8'h00);
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(stream_q[i], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("midrst");
    check("midrst_partial_writes", 32'(wa_q.size()), 32'd1);
    $display("midrst writes_before_reset=%0d", wa_q.size());
    run_load("midrst_reload", 1'b0, -1);

    // Full-size image boundary.
    src_words.delete();
    for (int i = 0; i < MAXW; i++) src_words.push_back($urandom);
    build_stream(MAXW, 8'h00);
    run_load("max", 1'b0, -1);

    // Random loads.
    for (int t = 0; t < 30; t++) begin
      int cnt;
      logic [7:0] ckx;
      int mid;
      cnt = $urandom_range(0, 12);
      if (t == 7)  cnt = MAXW + 1;
      if (t == 13) cnt = 16'hFFFF;
      ckx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      src_words.delete();
      for (int i = 0; i < cnt && i <= MAXW; i++) src_words.push_back($urandom);
      build_stream(cnt, ckx);
      mid = ($urandom_range(0, 1) == 1) ? $urandom_range(1, stream_q.size() - 1) : -1;
      run_load($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), mid);
    end

    check("we_back_to_back", 32'(we_double), 32'd0);
    check("we_outside_busy", 32'(we_outside), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
